seq_detector_param: RTL and testbench

Parametrised serial pattern detector, successor to the fixed 5-bit "11010" Moore FSM detector. It watches a 1-bit stream qualified by `in_valid` and matches it against a runtime-loadable pattern of 1..MAX_LEN bits, with overlapping or non-overlapping detection. A registered one-cycle `pattern_found` pulse is produced per match, and a saturating match counter is optional. It sits at the same point in the design as the fixed detector: serial stream in, detection pulse out to the downstream control logic.

---
 rtl/seq_detector_param.sv | 104 ++++++++++
 tb/tb_seq_detector_param.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with a runtime-loadable pattern of 1..MAX_LEN bits
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   in_valid       stream_in is sampled on this edge
//   stream_in      serial data bit
//   cfg_load       load cfg_pattern/cfg_len/cfg_overlap (rejected if cfg_len is 0 or > MAX_LEN)
//   cfg_pattern    pattern, bit cfg_len-1 received first, bit 0 last
//   cfg_len        pattern length
//   cfg_overlap    1 = overlapping detection, 0 = non-overlapping
//   cnt_clr        clears the match counter (wins over a same-edge match)
//   pattern_found  registered one-cycle pulse per match
//   match_count    saturating match count
//   count_sat      high while match_count is all-ones
//   cfg_err        sticky: the last cfg_load was rejected
//
// Build option: define SEQDET_MATCH_CNT_EN to build the match counter; otherwise
// match_count and count_sat are tied to 0 and cnt_clr is ignored.
module seq_detector_param #(
    parameter int                 MAX_LEN       = 16,
    parameter int                 LEN_W         = $clog2(MAX_LEN) + 1,
    parameter int                 CNT_W         = 16,
    parameter logic [MAX_LEN-1:0] RESET_PATTERN = 'b11010,
    parameter int                 RESET_LEN     = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               stream_in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               pattern_found,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat,
    output logic               cfg_err
);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist_q, pat_q, hist_d, mask;
    logic [LEN_W-1:0]   fill_q, len_q, fill_d;
    logic               ovl_q, found_q, err_q, cfg_ok, match;

    assign hist_d = {hist_q[MAX_LEN-2:0], stream_in};
    assign fill_d = (fill_q == MAX_L) ? fill_q : fill_q + LEN_W'(1);
    // Only the low len bits of history and pattern take part in the compare.
    assign mask   = {MAX_LEN{1'b1}} >> (MAX_L - len_q);
    assign cfg_ok = (cfg_len != '0) && (cfg_len <= MAX_L);
    // A load edge (legal or not) never samples the stream.
    assign match  = in_valid && !cfg_load && (fill_d >= len_q) && (((hist_d ^ pat_q) & mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= RESET_PATTERN;
            len_q   <= LEN_W'(RESET_LEN);
            ovl_q   <= 1'b1;
            found_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            found_q <= match;
            if (cfg_load) begin
                if (cfg_ok) begin
                    pat_q  <= cfg_pattern;
                    len_q  <= cfg_len;
                    ovl_q  <= cfg_overlap;
                    hist_q <= '0;
                    fill_q <= '0;
                    err_q  <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (in_valid) begin
                hist_q <= hist_d;
                // Non-overlapping mode forgets all bits consumed by a match.
                fill_q <= (match && !ovl_q) ? '0 : fill_d;
            end
        end
    end

    assign pattern_found = found_q;
    assign cfg_err       = err_q;

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) cnt_q <= '0;
        else if (match && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign match_count = cnt_q;
    assign count_sat   = &cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign match_count    = '0;
    assign count_sat      = 1'b0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed self-checking bench for seq_detector_param
module tb_seq_detector_param;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int CNT_W   = 4;
`ifdef SEQDET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               stream_in = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               pattern_found;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;
    logic               cfg_err;

    int total = 0;
    int bad   = 0;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stream_in(stream_in),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .pattern_found(pattern_found),
        .match_count(match_count), .count_sat(count_sat), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one input bit (or an idle cycle) and check the pulse that follows that edge.
    task automatic bit_in(input logic v, input logic b, input logic exp_found, input string tag);
        in_valid  = v;
        stream_in = b;
        tick();
        in_valid  = 1'b0;
        chk(tag, 32'(pattern_found), 32'(exp_found));
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_load    = 1'b1;
        in_valid    = 1'b1;
        stream_in   = 1'b1;
        tick();
        cfg_load = 1'b0;
        in_valid = 1'b0;
        chk("load_no_pulse", 32'(pattern_found), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_found", 32'(pattern_found), 0);
        chk("rst_count", 32'(match_count), 0);
        chk("rst_sat", 32'(count_sat), 0);
        chk("rst_err", 32'(cfg_err), 0);

        bit_in(1, 1, 0, "def_b1");
        bit_in(1, 1, 0, "def_b2");
        bit_in(1, 0, 0, "def_b3");
        bit_in(1, 1, 0, "def_b4");
        bit_in(1, 0, 1, "def_b5");
        chk("def_count", 32'(match_count), CNT_EN ? 1 : 0);
        chk("def_sat", 32'(count_sat), 0);
        bit_in(0, 0, 0, "def_idle");

        load(16'b101, 5'd3, 1'b1);
        clear_cnt();
        chk("clr_count", 32'(match_count), 0);
        bit_in(1, 1, 0, "ovl_b1");
        bit_in(1, 0, 0, "ovl_b2");
        bit_in(1, 1, 1, "ovl_b3");
        bit_in(1, 0, 0, "ovl_b4");
        bit_in(1, 1, 1, "ovl_b5");
        chk("ovl_count", 32'(match_count), CNT_EN ? 2 : 0);

        load(16'b101, 5'd3, 1'b0);
        clear_cnt();
        bit_in(1, 1, 0, "novl_b1");
        bit_in(1, 0, 0, "novl_b2");
        bit_in(1, 1, 1, "novl_b3");
        bit_in(1, 0, 0, "novl_b4");
        bit_in(1, 1, 0, "novl_b5");
        chk("novl_count", 32'(match_count), CNT_EN ? 1 : 0);

        do_reset();
        bit_in(1, 1, 0, "gap_b1");
        bit_in(0, 0, 0, "gap_i1");
        bit_in(1, 1, 0, "gap_b2");
        bit_in(0, 1, 0, "gap_i2");
        bit_in(1, 0, 0, "gap_b3");
        bit_in(0, 1, 0, "gap_i3");
        bit_in(1, 1, 0, "gap_b4");
        bit_in(0, 0, 0, "gap_i4");
        bit_in(1, 0, 1, "gap_b5");
        bit_in(0, 0, 0, "gap_after");

        bit_in(1, 1, 0, "rstmid_b1");
        bit_in(1, 1, 0, "rstmid_b2");
        bit_in(1, 0, 0, "rstmid_b3");
        bit_in(1, 1, 0, "rstmid_b4");
        do_reset();
        chk("rstmid_count", 32'(match_count), 0);
        bit_in(1, 0, 0, "rstmid_b5");

        load(16'b0, 5'd0, 1'b0);
        chk("ill_err_set", 32'(cfg_err), 1);
        bit_in(1, 1, 0, "ill_b1");
        bit_in(1, 1, 0, "ill_b2");
        bit_in(1, 0, 0, "ill_b3");
        bit_in(1, 1, 0, "ill_b4");
        bit_in(1, 0, 1, "ill_b5");
        chk("ill_err_sticky", 32'(cfg_err), 1);
        load(16'b0, 5'd17, 1'b0);
        chk("ill_err_long", 32'(cfg_err), 1);

        load(16'b1001, 5'd4, 1'b1);
        chk("legal_err_clr", 32'(cfg_err), 0);
        bit_in(1, 1, 0, "l4_b1");
        bit_in(1, 0, 0, "l4_b2");
        bit_in(1, 0, 0, "l4_b3");
        bit_in(1, 1, 1, "l4_b4");

        do_reset();
        load(16'b1, 5'd1, 1'b1);
        for (int i = 1; i <= 17; i++) begin
            bit_in(1, 1, 1, $sformatf("sat_found_%0d", i));
            chk($sformatf("sat_count_%0d", i), 32'(match_count), CNT_EN ? ((i > 15) ? 15 : i) : 0);
            chk($sformatf("sat_flag_%0d", i), 32'(count_sat), (CNT_EN && i >= 15) ? 1 : 0);
        end
        bit_in(0, 1, 0, "sat_idle");
        bit_in(1, 0, 0, "sat_zero");
        cnt_clr = 1'b1;
        bit_in(1, 1, 1, "clr_match_found");
        cnt_clr = 1'b0;
        chk("clr_match_count", 32'(match_count), 0);
        chk("clr_match_sat", 32'(count_sat), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
